spi_cmd_master: RTL and testbench

- SPI mode-0 initiator that issues single-opcode flash transactions (e.g. 0x9E read-ID, 0x03 read) to an external serial NOR device.
- Accepts a command descriptor over a valid/ready handshake, drives SS/SCLK/MOSI, and returns the response bytes one at a time as a stream.
- Sits between the bus-side flash controller logic and the SPI pads.
- Also serves as the stimulus driver for flash-model testbenches.

---
 rtl/spi_cmd_master_if.sv | 34 +++
 rtl/spi_cmd_master.sv | 156 +++++++++++++++
 tb/tb_spi_cmd_master.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_master_if.sv
// Command/response stream and SPI pad signals of the flash command initiator.
// "master" is the initiator side; "slave" is the requester and pad side.
interface spi_cmd_master_if #(
  parameter int ADDR_BYTES = 3,
  parameter int LEN_WIDTH  = 8
);
  logic                    io_cmd_valid;
  logic                    io_cmd_ready;
  logic [7:0]              io_cmd_opcode;
  logic                    io_cmd_has_addr;
  logic [8*ADDR_BYTES-1:0] io_cmd_addr;
  logic [LEN_WIDTH-1:0]    io_cmd_rsp_len;
  logic                    io_rsp_valid;
  logic [7:0]              io_rsp_data;
  logic                    io_busy;
  logic                    io_spi_sclk;
  logic                    io_spi_mosi;
  logic                    io_spi_miso;
  logic                    io_spi_ss;

  modport master (
    input  io_cmd_valid, io_cmd_opcode, io_cmd_has_addr, io_cmd_addr, io_cmd_rsp_len,
    input  io_spi_miso,
    output io_cmd_ready, io_rsp_valid, io_rsp_data, io_busy,
    output io_spi_sclk, io_spi_mosi, io_spi_ss
  );

  modport slave (
    output io_cmd_valid, io_cmd_opcode, io_cmd_has_addr, io_cmd_addr, io_cmd_rsp_len,
    output io_spi_miso,
    input  io_cmd_ready, io_rsp_valid, io_rsp_data, io_busy,
    input  io_spi_sclk, io_spi_mosi, io_spi_ss
  );
endinterface

// File: rtl/spi_cmd_master.sv
// SPI mode-0 initiator: one opcode, optional address, N response bytes per command.
// Every SCLK edge and phase change happens on a divider tick (one tick per CLK_DIV cycles).
module spi_cmd_master #(
  parameter int CLK_DIV    = 4,
  parameter int ADDR_BYTES = 3,
  parameter int LEN_WIDTH  = 8
) (
  input logic              io_clk,
  input logic              io_rst,
  spi_cmd_master_if.master bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TX_W  = 8 * (1 + ADDR_BYTES);

  typedef enum logic [2:0] {IDLE, SETUP, CMD, ADDR, RSP, HOLD, GAP} state_t;

  state_t               state_reg, state_next;
  logic [DIV_W-1:0]     div_reg, div_next;
  logic [2:0]           bit_reg, bit_next;
  logic [1:0]           abyte_reg, abyte_next;
  logic [LEN_WIDTH-1:0] rcnt_reg, rcnt_next;
  logic                 has_addr_reg, has_addr_next;
  logic [TX_W-1:0]      tx_reg, tx_next;
  logic [7:0]           rx_reg, rx_next;
  logic [7:0]           data_reg, data_next;
  logic                 valid_reg, valid_next;
  logic                 sclk_reg, sclk_next;
  logic                 mosi_reg, mosi_next;
  logic                 ss_reg, ss_next;
  logic                 tick;

  assign tick = (div_reg == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      state_reg    <= IDLE;
      div_reg      <= '0;
      bit_reg      <= '0;
      abyte_reg    <= '0;
      rcnt_reg     <= '0;
      has_addr_reg <= 1'b0;
      tx_reg       <= '0;
      rx_reg       <= '0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      ss_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      bit_reg      <= bit_next;
      abyte_reg    <= abyte_next;
      rcnt_reg     <= rcnt_next;
      has_addr_reg <= has_addr_next;
      tx_reg       <= tx_next;
      rx_reg       <= rx_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      sclk_reg     <= sclk_next;
      mosi_reg     <= mosi_next;
      ss_reg       <= ss_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    div_next      = tick ? '0 : div_reg + 1'b1;
    bit_next      = bit_reg;
    abyte_next    = abyte_reg;
    rcnt_next     = rcnt_reg;
    has_addr_next = has_addr_reg;
    tx_next       = tx_reg;
    rx_next       = rx_reg;
    data_next     = data_reg;
    valid_next    = 1'b0;
    sclk_next     = sclk_reg;
    mosi_next     = mosi_reg;
    ss_next       = ss_reg;

    case (state_reg)
      IDLE: begin
        if (bus.io_cmd_valid) begin
          state_next    = SETUP;
          div_next      = '0;
          ss_next       = 1'b0;
          tx_next       = {bus.io_cmd_opcode, bus.io_cmd_addr};
          mosi_next     = bus.io_cmd_opcode[7];
          has_addr_next = bus.io_cmd_has_addr;
          rcnt_next     = bus.io_cmd_rsp_len;
          bit_next      = '0;
          abyte_next    = '0;
        end
      end
      SETUP: begin
        if (tick) state_next = CMD;
      end
      CMD, ADDR, RSP: begin
        if (tick) begin
          sclk_next = ~sclk_reg;
          if (!sclk_reg) begin
            rx_next = {rx_reg[6:0], bus.io_spi_miso};
            if (state_reg == RSP && bit_reg == 3'd7) begin
              valid_next = 1'b1;
              data_next  = {rx_reg[6:0], bus.io_spi_miso};
            end
          end else begin
            // Falling edge: advance the bit and present the next MOSI bit.
            bit_next  = bit_reg + 1'b1;
            tx_next   = tx_reg << 1;
            mosi_next = (state_reg == RSP) ? 1'b0 : tx_reg[TX_W-2];
            if (bit_reg == 3'd7) begin
              if (state_reg == CMD) begin
                if (has_addr_reg) begin
                  state_next = ADDR;
                end else begin
                  mosi_next  = 1'b0;
                  state_next = (rcnt_reg != '0) ? RSP : HOLD;
                end
              end else if (state_reg == ADDR) begin
                if (abyte_reg == 2'(ADDR_BYTES - 1)) begin
                  mosi_next  = 1'b0;
                  state_next = (rcnt_reg != '0) ? RSP : HOLD;
                end else begin
                  abyte_next = abyte_reg + 1'b1;
                end
              end else begin
                // Count down from rsp_len so the maximum length never wraps early.
                rcnt_next = rcnt_reg - 1'b1;
                if (rcnt_reg == LEN_WIDTH'(1)) state_next = HOLD;
              end
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          ss_next    = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        if (tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.io_cmd_ready = (state_reg == IDLE);
  assign bus.io_busy      = (state_reg != IDLE);
  assign bus.io_rsp_valid = valid_reg;
  assign bus.io_rsp_data  = data_reg;
  assign bus.io_spi_sclk  = sclk_reg;
  assign bus.io_spi_mosi  = mosi_reg;
  assign bus.io_spi_ss    = ss_reg;
endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: one instance at CLK_DIV=4 and one at CLK_DIV=1, each with
// a serial-flash response model and a bus/pad monitor.
module tb_spi_cmd_master;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid    [2];
  logic [7:0] cmd_opcode   [2];
  logic       cmd_has_addr [2];
  logic [23:0] cmd_addr    [2];
  logic [7:0] cmd_rsp_len  [2];
  logic [31:0] pat         [2];
  int         hdr_bits     [2];

  logic       ready [2], busy [2], ss [2], sclk [2], mosi [2], rsp_valid [2];
  logic [7:0] rsp_data [2];

  int          m_rise [2], m_ones [2], m_low [2], m_gap [2], m_viol [2];
  int          m_hs [2], m_nrsp [2], m_dbl [2];
  logic [31:0] m_hdr [2], m_word [2];
  logic [7:0]  m_last [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      spi_cmd_master_if #(.ADDR_BYTES(3), .LEN_WIDTH(8)) bus ();

      spi_cmd_master #(.CLK_DIV(gi == 0 ? 4 : 1), .ADDR_BYTES(3), .LEN_WIDTH(8)) u_dut (
        .io_clk (clk),
        .io_rst (rst),
        .bus    (bus.master)
      );

      int          rise_tot = 0, rise_start = 0, ones = 0, low = 0, high = 0, gap = 0;
      int          viol = 0, hs = 0, nrsp = 0, dbl = 0;
      logic [31:0] hdr = '0, word = '0;
      logic [7:0]  last = '0;
      logic        ss_d = 1'b1, rv_d = 1'b0;
      int          rel, bidx;
      logic [7:0]  rbyte;
      logic        miso_v;

      assign bus.io_cmd_valid    = cmd_valid[gi];
      assign bus.io_cmd_opcode   = cmd_opcode[gi];
      assign bus.io_cmd_has_addr = cmd_has_addr[gi];
      assign bus.io_cmd_addr     = cmd_addr[gi];
      assign bus.io_cmd_rsp_len  = cmd_rsp_len[gi];
      assign bus.io_spi_miso     = miso_v;

      assign ready[gi]     = bus.io_cmd_ready;
      assign busy[gi]      = bus.io_busy;
      assign ss[gi]        = bus.io_spi_ss;
      assign sclk[gi]      = bus.io_spi_sclk;
      assign mosi[gi]      = bus.io_spi_mosi;
      assign rsp_valid[gi] = bus.io_rsp_valid;
      assign rsp_data[gi]  = bus.io_rsp_data;

      assign m_rise[gi] = rise_tot - rise_start;
      assign m_ones[gi] = ones;
      assign m_low[gi]  = low;
      assign m_gap[gi]  = gap;
      assign m_viol[gi] = viol;
      assign m_hs[gi]   = hs;
      assign m_nrsp[gi] = nrsp;
      assign m_dbl[gi]  = dbl;
      assign m_hdr[gi]  = hdr;
      assign m_word[gi] = word;
      assign m_last[gi] = last;

      // Flash model: after the header bits, stream pat bytes, then byte index ^ 0x5A.
      always_comb begin
        rel    = rise_tot - rise_start - hdr_bits[gi];
        bidx   = 0;
        rbyte  = 8'h00;
        miso_v = 1'b0;
        if (rel >= 0) begin
          bidx   = rel >> 3;
          rbyte  = (bidx < 4) ? pat[gi][31 - 8*bidx -: 8] : (bidx[7:0] ^ 8'h5A);
          miso_v = rbyte[7 - (rel & 7)];
        end
      end

      always @(negedge bus.io_spi_ss) rise_start <= rise_tot;

      always @(posedge bus.io_spi_sclk) begin
        rise_tot <= rise_tot + 1;
        if (rise_tot - rise_start == 0) hdr <= {bus.io_spi_mosi, 31'b0};
        else if (rise_tot - rise_start < 32) hdr[31 - (rise_tot - rise_start)] <= bus.io_spi_mosi;
        else if (bus.io_spi_mosi) ones <= ones + 1;
      end

      always @(posedge clk) begin
        ss_d <= bus.io_spi_ss;
        rv_d <= bus.io_rsp_valid;
        if (bus.io_spi_ss === 1'b0) low <= ss_d ? 1 : low + 1;
        else high <= ss_d ? high + 1 : 1;
        if (ss_d === 1'b1 && bus.io_spi_ss === 1'b0) begin
          gap  <= high;
          nrsp <= 0;
          word <= '0;
          last <= '0;
        end else if (bus.io_rsp_valid === 1'b1) begin
          if (nrsp < 4) word[31 - 8*nrsp -: 8] <= bus.io_rsp_data;
          last <= bus.io_rsp_data;
          nrsp <= nrsp + 1;
        end
        if (bus.io_spi_ss !== ss_d && bus.io_spi_sclk === 1'b1) viol <= viol + 1;
        if (bus.io_rsp_valid === 1'b1 && rv_d === 1'b1) dbl <= dbl + 1;
        if (bus.io_cmd_valid === 1'b1 && bus.io_cmd_ready === 1'b1) hs <= hs + 1;
      end
    end
  endgenerate

  typedef struct {
    int          d;
    logic [7:0]  op;
    logic        ha;
    logic [23:0] addr;
    logic [7:0]  len;
    logic [31:0] pat;
    int          exp_rise;
    int          exp_low;
    logic [31:0] exp_hdr;
    int          exp_nrsp;
    logic [31:0] exp_word;
    logic [7:0]  exp_last;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic issue(input int d, input logic [7:0] op, input logic ha, input logic [23:0] addr,
                       input logic [7:0] len, output bit ok);
    int n = 0;
    @(negedge clk);
    cmd_opcode[d] = op; cmd_has_addr[d] = ha; cmd_addr[d] = addr; cmd_rsp_len[d] = len;
    cmd_valid[d] = 1'b1;
    while (ready[d] !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    // Scramble the descriptor: the DUT must use its latched copy.
    cmd_valid[d] = 1'b0; cmd_opcode[d] = ~op; cmd_has_addr[d] = ~ha;
    cmd_addr[d] = ~addr; cmd_rsp_len[d] = ~len;
    ok = (n < 1000);
  endtask

  task automatic wait_idle(input int d, input int budget, output bit ok);
    int n = 0;
    @(negedge clk);
    while (busy[d] !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    ok = (n < budget);
  endtask

  task automatic wait_hs(input int d, input int target, input int budget, output bit ok);
    int n = 0;
    while (m_hs[d] != target && n < budget) begin @(negedge clk); n++; end
    ok = (n < budget);
  endtask

  vec_t v [6];
  int   d, ones0, dbl0, viol0, hs0;
  bit   ok;

  initial begin
    v[0] = '{0, 8'h9E, 1'b0, 24'h000000, 8'd3,   32'h20BA1800, 32,   264,   32'h9E000000, 3,   32'h20BA1800, 8'h18};
    v[1] = '{0, 8'h03, 1'b1, 24'h123456, 8'd2,   32'hA53C0000, 48,   392,   32'h03123456, 2,   32'hA53C0000, 8'h3C};
    v[2] = '{0, 8'h06, 1'b0, 24'h000000, 8'd0,   32'h00000000, 8,    72,    32'h06000000, 0,   32'h00000000, 8'h00};
    v[3] = '{0, 8'h0B, 1'b1, 24'h800001, 8'd255, 32'h11223344, 2072, 16584, 32'h0B800001, 255, 32'h11223344, 8'hA4};
    v[4] = '{1, 8'h9E, 1'b0, 24'h000000, 8'd1,   32'h20000000, 16,   34,    32'h9E000000, 1,   32'h20000000, 8'h20};
    v[5] = '{1, 8'h03, 1'b1, 24'hABCDEF, 8'd1,   32'hE7000000, 40,   82,    32'h03ABCDEF, 1,   32'hE7000000, 8'hE7};

    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0; cmd_opcode[i] = '0; cmd_has_addr[i] = 1'b0;
      cmd_addr[i] = '0; cmd_rsp_len[i] = '0; pat[i] = '0; hdr_bits[i] = 8;
    end

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_rst_ss", i), ss[i], 1);
      chk($sformatf("d%0d_rst_sclk", i), sclk[i], 0);
      chk($sformatf("d%0d_rst_mosi", i), mosi[i], 0);
      chk($sformatf("d%0d_rst_rsp_valid", i), rsp_valid[i], 0);
      chk($sformatf("d%0d_rst_rsp_data", i), rsp_data[i], 0);
      chk($sformatf("d%0d_rst_busy", i), busy[i], 0);
      chk($sformatf("d%0d_rst_ready", i), ready[i], 1);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during the second byte of a 4-byte read.
    pat[0] = 32'h11223344; hdr_bits[0] = 32;
    issue(0, 8'h03, 1'b1, 24'h000010, 8'd4, ok);
    chk("rstmid_accept", ok, 1);
    begin
      int n = 0;
      while (m_nrsp[0] != 1 && n < 2000) begin @(negedge clk); n++; end
      chk("rstmid_first_byte_seen", (n < 2000), 1);
    end
    chk("rstmid_byte0", m_word[0][31:24], 8'h11);
    repeat (20) @(negedge clk);
    chk("rstmid_busy_before", busy[0], 1);
    rst = 1'b1;
    #1;
    chk("rstmid_ss", ss[0], 1);
    chk("rstmid_sclk", sclk[0], 0);
    chk("rstmid_busy", busy[0], 0);
    chk("rstmid_ready", ready[0], 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("rstmid_no_more_rsp", m_nrsp[0], 1);
    chk("rstmid_rsp_data_cleared", rsp_data[0], 0);

    // Directed command table.
    for (int i = 0; i < 6; i++) begin
      d = v[i].d;
      pat[d] = v[i].pat;
      hdr_bits[d] = v[i].ha ? 32 : 8;
      ones0 = m_ones[d]; dbl0 = m_dbl[d]; viol0 = m_viol[d];
      issue(d, v[i].op, v[i].ha, v[i].addr, v[i].len, ok);
      chk($sformatf("v%0d_accept", i), ok, 1);
      wait_idle(d, 20000, ok);
      chk($sformatf("v%0d_done", i), ok, 1);
      chk($sformatf("v%0d_rises", i), m_rise[d], v[i].exp_rise);
      chk($sformatf("v%0d_ss_low_cycles", i), m_low[d], v[i].exp_low);
      chk($sformatf("v%0d_mosi_header", i), m_hdr[d], v[i].exp_hdr);
      chk($sformatf("v%0d_mosi_rsp_ones", i), m_ones[d] - ones0, 0);
      chk($sformatf("v%0d_rsp_count", i), m_nrsp[d], v[i].exp_nrsp);
      chk($sformatf("v%0d_rsp_first4", i), m_word[d], v[i].exp_word);
      chk($sformatf("v%0d_rsp_last", i), m_last[d], v[i].exp_last);
      chk($sformatf("v%0d_pulse_width", i), m_dbl[d] - dbl0, 0);
      chk($sformatf("v%0d_sclk_at_ss_edge", i), m_viol[d] - viol0, 0);
      chk($sformatf("v%0d_ready", i), ready[d], 1);
      chk($sformatf("v%0d_ss_idle", i), ss[d], 1);
      chk($sformatf("v%0d_sclk_idle", i), sclk[d], 0);
      if (v[i].exp_nrsp > 0) chk($sformatf("v%0d_rsp_data_held", i), rsp_data[d], v[i].exp_last);
    end

    // Back-to-back: valid held high across two descriptors.
    pat[0] = 32'h20BA1800; hdr_bits[0] = 8;
    hs0 = m_hs[0]; viol0 = m_viol[0];
    @(negedge clk);
    cmd_opcode[0] = 8'h9E; cmd_has_addr[0] = 1'b0; cmd_addr[0] = '0; cmd_rsp_len[0] = 8'd1;
    cmd_valid[0] = 1'b1;
    wait_hs(0, hs0 + 1, 100, ok);
    chk("b2b_first_hs", ok, 1);
    cmd_opcode[0] = 8'h05;
    wait_hs(0, hs0 + 2, 2000, ok);
    chk("b2b_second_hs", ok, 1);
    chk("b2b_a_header", m_hdr[0], 32'h9E000000);
    chk("b2b_a_rsp_count", m_nrsp[0], 1);
    chk("b2b_a_rsp", m_word[0], 32'h20000000);
    cmd_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (m_gap[0] < 4) begin
      failures++;
      $display("FAIL b2b_ss_gap actual=%0d required>=4", m_gap[0]);
    end else begin
      $display("ok   b2b_ss_gap = %0d", m_gap[0]);
    end
    wait_idle(0, 2000, ok);
    chk("b2b_done", ok, 1);
    chk("b2b_b_header", m_hdr[0], 32'h05000000);
    chk("b2b_b_rsp", m_last[0], 8'h20);
    chk("b2b_hs_total", m_hs[0] - hs0, 2);
    chk("b2b_sclk_at_ss_edge", m_viol[0] - viol0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
